// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control sequencer: opcodes, the
// step/state encoding, instruction classes and the datapath strobe bundle.
// Optional feature macro: CU_MULDIV_EN (enables mul/div decode and their E6 step).
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET, S_F0, S_F1, S_F2, S_E3, S_E4, S_E5, S_E6, S_E7, S_HALT, S_TRAP
    } cu_state_e;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_NEGNOT, C_MULDIV, C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cu_class_e;

    typedef struct packed {
        logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, ramWE;
        logic Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout;
        logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, InPortout, OutPort_enable;
    } cu_strobes_t;

    // Sequential successor of an execute step (the FSM decides whether to take it).
    function automatic cu_state_e next_exec(input cu_state_e s);
        case (s)
            S_E3:    return S_E4;
            S_E4:    return S_E5;
            S_E5:    return S_E6;
            S_E6:    return S_E7;
            default: return S_F0;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Sequencer <-> datapath bundle. The master side is the sequencer (drives the
// strobes), the slave side is the datapath / memory / control inputs.
interface mc_sequencer_if #(
    parameter int REG_COUNT = 16,
    parameter int IR_W      = 32
);
    logic [IR_W-1:0]      IR;
    logic                 con_ff;
    logic                 mem_ack;
    logic                 stop;
    logic                 resume;

    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, ramWE;
    logic Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, InPortout, OutPort_enable;
    logic [REG_COUNT-1:0] r_force_in;
    logic [4:0]           alu_op;
    logic                 Run;
    logic                 illegal_op;

    modport master (
        input  IR, con_ff, mem_ack, stop, resume,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, ramWE,
        output Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, InPortout, OutPort_enable,
        output r_force_in, alu_op, Run, illegal_op
    );

    modport slave (
        output IR, con_ff, mem_ack, stop, resume,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, ramWE,
        input  Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, InPortout, OutPort_enable,
        input  r_force_in, alu_op, Run, illegal_op
    );
endinterface

// File: rtl/cu_decode.sv
// Opcode -> instruction class decode. Unlisted opcodes flag illegal.
// mul/div are legal only when CU_MULDIV_EN is defined.
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output cu_class_e  cls_o,
    output logic       illegal_o
);

    // Pure table lookup; class defaults to NOP so illegal codes carry no strobes.
    always_comb begin
        cls_o     = C_NOP;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_LD:   cls_o = C_LD;
            OP_LDI:  cls_o = C_LDI;
            OP_ST:   cls_o = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                     cls_o = C_RALU;
            OP_ADDI, OP_ANDI, OP_ORI:
                     cls_o = C_IALU;
`ifdef CU_MULDIV_EN
            OP_MUL, OP_DIV:
                     cls_o = C_MULDIV;
`else
            OP_MUL, OP_DIV:
                     illegal_o = 1'b1;
`endif
            OP_NEG, OP_NOT:
                     cls_o = C_NEGNOT;
            OP_BR:   cls_o = C_BR;
            OP_JR:   cls_o = C_JR;
            OP_JAL:  cls_o = C_JAL;
            OP_IN:   cls_o = C_IN;
            OP_OUT:  cls_o = C_OUT;
            OP_MFHI: cls_o = C_MFHI;
            OP_MFLO: cls_o = C_MFLO;
            OP_NOP:  cls_o = C_NOP;
            OP_HALT: cls_o = C_HALT;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: fetch/decode/execute strobes for the 32-bit
// register-file datapath with ack-based memory waits, stop/resume at
// instruction boundaries and illegal-opcode trapping.
// Optional feature macro: CU_MULDIV_EN (mul/div support, E6 HI write step).
module mc_sequencer
    import cu_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int LINK_REG  = 15,
    parameter int IR_W      = 32
)(
    input  logic          clk,
    input  logic          rst,
    mc_sequencer_if.master bus
);

    cu_state_e   state_q;
    cu_class_e   cls_q;
    logic        illegal_q;

    cu_class_e   dec_cls;
    logic        dec_ill;
    logic        last_step;
    logic        hold_step;
    logic        force_link;
    cu_strobes_t st;
    logic [4:0]  opcode;
    logic [REG_COUNT-1:0] force_vec;
    logic        unused_ir;

    assign opcode    = bus.IR[IR_W-1 -: 5];
    assign unused_ir = ^bus.IR[IR_W-6:0];

    cu_decode u_decode (
        .opcode_i  (opcode),
        .cls_o     (dec_cls),
        .illegal_o (dec_ill)
    );

    // Is the current execute step the instruction's final one, or is it stalled on memory?
    always_comb begin
        last_step = 1'b0;
        hold_step = 1'b0;
        case (state_q)
            S_E3: last_step = cls_q inside {C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP};
            S_E4: last_step = cls_q inside {C_NEGNOT, C_JAL};
            S_E5: last_step = (cls_q inside {C_RALU, C_IALU, C_LDI}) ||
                              (cls_q == C_BR && !bus.con_ff);
            S_E6: begin
                if (cls_q == C_BR) last_step = 1'b1;
`ifdef CU_MULDIV_EN
                if (cls_q == C_MULDIV) last_step = 1'b1;
`endif
                if (cls_q == C_LD) hold_step = !bus.mem_ack;
            end
            S_E7: begin
                if (cls_q == C_ST) begin
                    last_step = bus.mem_ack;
                    hold_step = !bus.mem_ack;
                end else begin
                    last_step = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Step sequencing, class latch at decode and the sticky illegal flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_RESET;
            cls_q     <= C_NOP;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_RESET: state_q <= S_F0;
                S_F0:    state_q <= S_F1;
                S_F1:    if (bus.mem_ack) state_q <= S_F2;
                S_F2: begin
                    cls_q <= dec_cls;
                    if (dec_ill) begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end else if (dec_cls == C_HALT) begin
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_E3;
                    end
                end
                S_TRAP:  state_q <= S_HALT;
                S_HALT: begin
                    if (bus.resume) begin
                        state_q   <= S_F0;
                        illegal_q <= 1'b0;
                    end
                end
                default: begin
                    // stop only takes effect once the instruction's last step completes
                    if (last_step)       state_q <= bus.stop ? S_HALT : S_F0;
                    else if (!hold_step) state_q <= next_exec(state_q);
                end
            endcase
        end
    end

    // Strobes decoded from the current step and latched instruction class.
    always_comb begin
        st         = '0;
        force_link = 1'b0;
        case (state_q)
            S_F0: begin st.PCout = 1'b1; st.MARin = 1'b1; st.IncPC = 1'b1; st.ZLowIn = 1'b1; end
            S_F1: begin
                st.ZLowout = 1'b1; st.Read = 1'b1; st.MDRin = 1'b1;
                st.PCin    = bus.mem_ack;   // PC commits only once the fetch completes
            end
            S_F2: begin st.MDRout = 1'b1; st.IRin = 1'b1; end
            S_E3: case (cls_q)
                C_RALU, C_IALU: begin st.Grb = 1'b1; st.Rout = 1'b1; st.Yin = 1'b1; end
                C_NEGNOT: begin st.Grb = 1'b1; st.Rout = 1'b1; st.ZLowIn = 1'b1; st.ZHighIn = 1'b1; end
`ifdef CU_MULDIV_EN
                C_MULDIV: begin st.Gra = 1'b1; st.Rout = 1'b1; st.Yin = 1'b1; end
`endif
                C_LD, C_LDI, C_ST: begin st.Grb = 1'b1; st.BAout = 1'b1; st.Yin = 1'b1; end
                C_BR:   begin st.Gra = 1'b1; st.Rout = 1'b1; st.CONin = 1'b1; end
                C_JR:   begin st.Gra = 1'b1; st.Rout = 1'b1; st.PCin = 1'b1; end
                C_JAL:  begin st.PCout = 1'b1; force_link = 1'b1; end
                C_IN:   begin st.Gra = 1'b1; st.Rin = 1'b1; st.InPortout = 1'b1; end
                C_OUT:  begin st.Gra = 1'b1; st.Rout = 1'b1; st.OutPort_enable = 1'b1; end
                C_MFHI: begin st.Gra = 1'b1; st.Rin = 1'b1; st.HIout = 1'b1; end
                C_MFLO: begin st.Gra = 1'b1; st.Rin = 1'b1; st.LOout = 1'b1; end
                default: ;
            endcase
            S_E4: case (cls_q)
                C_RALU: begin st.Grc = 1'b1; st.Rout = 1'b1; st.ZLowIn = 1'b1; st.ZHighIn = 1'b1; end
                C_IALU, C_LD, C_LDI, C_ST:
                        begin st.Cout = 1'b1; st.ZLowIn = 1'b1; st.ZHighIn = 1'b1; end
                C_NEGNOT: begin st.ZLowout = 1'b1; st.Gra = 1'b1; st.Rin = 1'b1; end
`ifdef CU_MULDIV_EN
                C_MULDIV: begin st.Grb = 1'b1; st.Rout = 1'b1; st.ZLowIn = 1'b1; st.ZHighIn = 1'b1; end
`endif
                C_BR:   begin st.PCout = 1'b1; st.Yin = 1'b1; end
                C_JAL:  begin st.Gra = 1'b1; st.Rout = 1'b1; st.PCin = 1'b1; end
                default: ;
            endcase
            S_E5: case (cls_q)
                C_RALU, C_IALU, C_LDI: begin st.ZLowout = 1'b1; st.Gra = 1'b1; st.Rin = 1'b1; end
`ifdef CU_MULDIV_EN
                C_MULDIV: begin st.ZLowout = 1'b1; st.LOin = 1'b1; end
`endif
                C_LD, C_ST: begin st.ZLowout = 1'b1; st.MARin = 1'b1; end
                C_BR:   begin st.Cout = 1'b1; st.ZLowIn = 1'b1; st.ZHighIn = 1'b1; end
                default: ;
            endcase
            S_E6: case (cls_q)
`ifdef CU_MULDIV_EN
                C_MULDIV: begin st.ZHighout = 1'b1; st.HIin = 1'b1; end
`endif
                C_LD:   begin st.Read = 1'b1; st.MDRin = 1'b1; end
                C_ST:   begin st.Gra = 1'b1; st.Rout = 1'b1; st.MDRin = 1'b1; end
                C_BR:   begin st.ZLowout = 1'b1; st.PCin = 1'b1; end
                default: ;
            endcase
            S_E7: case (cls_q)
                C_LD:   begin st.MDRout = 1'b1; st.Gra = 1'b1; st.Rin = 1'b1; end
                C_ST:   begin st.MDRout = 1'b1; st.ramWE = 1'b1; end
                default: ;
            endcase
            default: ;
        endcase
    end

    // One-hot link-register write for jal.
    always_comb begin
        force_vec = '0;
        if (force_link) force_vec[LINK_REG] = 1'b1;
    end

    assign bus.PCout          = st.PCout;
    assign bus.PCin           = st.PCin;
    assign bus.IncPC          = st.IncPC;
    assign bus.MARin          = st.MARin;
    assign bus.MDRin          = st.MDRin;
    assign bus.MDRout         = st.MDRout;
    assign bus.IRin           = st.IRin;
    assign bus.Read           = st.Read;
    assign bus.ramWE          = st.ramWE;
    assign bus.Yin            = st.Yin;
    assign bus.ZLowIn         = st.ZLowIn;
    assign bus.ZHighIn        = st.ZHighIn;
    assign bus.ZLowout        = st.ZLowout;
    assign bus.ZHighout       = st.ZHighout;
    assign bus.HIin           = st.HIin;
    assign bus.LOin           = st.LOin;
    assign bus.HIout          = st.HIout;
    assign bus.LOout          = st.LOout;
    assign bus.Gra            = st.Gra;
    assign bus.Grb            = st.Grb;
    assign bus.Grc            = st.Grc;
    assign bus.Rin            = st.Rin;
    assign bus.Rout           = st.Rout;
    assign bus.BAout          = st.BAout;
    assign bus.Cout           = st.Cout;
    assign bus.CONin          = st.CONin;
    assign bus.InPortout      = st.InPortout;
    assign bus.OutPort_enable = st.OutPort_enable;
    assign bus.r_force_in     = force_vec;
    // The ALU sees the opcode only while Z is being loaded.
    assign bus.alu_op         = (st.ZLowIn && st.ZHighIn) ? opcode : 5'b00000;
    assign bus.Run            = state_q inside {S_F0, S_F1, S_F2, S_E3, S_E4, S_E5, S_E6, S_E7};
    assign bus.illegal_op     = illegal_q;

endmodule
